// File: rtl/melody_game_pkg.sv
// Shared types and width helpers for the melody recall game engine.
package melody_game_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPlayOn,
        StPlayOff,
        StWaitKey,
        StEcho,
        StWin,
        StLose
    } state_e;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned width_for(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Emits a one-clock tick every TICK_DIV clocks; restart realigns the phase to zero.
module tick_prescaler
    import melody_game_pkg::*;
#(
    parameter int unsigned TICK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CntW = width_for(TICK_DIV);
    localparam logic [CntW-1:0] Last = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (restart || cnt_q == Last) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign tick = (cnt_q == Last);

endmodule

// File: rtl/melody_recall_game.sv
// Melody recall game: plays a growing prefix of a stored melody, then scores keypad entries.
module melody_recall_game
    import melody_game_pkg::*;
#(
    parameter int unsigned NOTE_W     = 4,
    parameter int unsigned MAX_NOTES  = 8,
    parameter int unsigned START_LEN  = 3,
    parameter int unsigned TICK_DIV   = 2,
    parameter int unsigned ON_TICKS   = 2,
    parameter int unsigned OFF_TICKS  = 2,
    parameter int unsigned ECHO_TICKS = 1,
    parameter int unsigned LIVES      = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [MAX_NOTES*NOTE_W-1:0]     melody_in,
    input  logic                            load,
    input  logic                            start,
    input  logic                            reverse_mode,
    input  logic                            key_valid,
    input  logic [NOTE_W-1:0]               key_code,
    output logic [NOTE_W-1:0]               piezo_out,
    output logic [NOTE_W-1:0]               led_out,
    output logic                            busy,
    output logic [$clog2(MAX_NOTES+1)-1:0]  cur_len,
    output logic [$clog2(LIVES+1)-1:0]      miss_cnt,
    output logic                            game_win,
    output logic                            game_over
);

    localparam int unsigned IdxW  = width_for(MAX_NOTES);
    localparam int unsigned LenW  = $clog2(MAX_NOTES + 1);
    localparam int unsigned MissW = $clog2(LIVES + 1);
    localparam int unsigned TkMax = (ON_TICKS > OFF_TICKS)
                                  ? ((ON_TICKS > ECHO_TICKS) ? ON_TICKS : ECHO_TICKS)
                                  : ((OFF_TICKS > ECHO_TICKS) ? OFF_TICKS : ECHO_TICKS);
    localparam int unsigned TkW   = width_for(TkMax + 1);

    state_e                        state_q, state_d;
    logic [MAX_NOTES*NOTE_W-1:0]   melody_q, melody_d;
    logic                          loaded_q, loaded_d;
    logic [IdxW-1:0]               idx_q, idx_d, exp_q, exp_d;
    logic [LenW-1:0]               len_q, len_d;
    logic [MissW-1:0]              miss_q, miss_d, miss_inc;
    logic                          rev_q, rev_d, hit_q, hit_d;
    logic                          win_q, win_d, over_q, over_d;
    logic [TkW-1:0]                ticks_q, ticks_d;
    logic [NOTE_W-1:0]             piezo_q, piezo_d;
    logic                          tick, expire, play_last, entry_last;

    function automatic logic [NOTE_W-1:0] note_at(input logic [MAX_NOTES*NOTE_W-1:0] mel,
                                                  input logic [IdxW-1:0] i);
        return mel[int'(i)*NOTE_W +: NOTE_W];
    endfunction

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .restart (state_d != state_q),
        .tick    (tick)
    );

    assign expire     = tick && (ticks_q == TkW'(1));
    assign play_last  = (LenW'(idx_q) == len_q - LenW'(1));
    // Reverse entry ends at index 0, forward entry at the last note of the prefix.
    assign entry_last = rev_q ? (exp_q == '0) : (LenW'(exp_q) == len_q - LenW'(1));
    assign miss_inc   = miss_q + MissW'(1);

    always_comb begin
        state_d  = state_q;
        melody_d = melody_q;
        loaded_d = loaded_q;
        idx_d    = idx_q;
        exp_d    = exp_q;
        len_d    = len_q;
        miss_d   = miss_q;
        rev_d    = rev_q;
        hit_d    = hit_q;
        win_d    = win_q;
        over_d   = over_q;
        ticks_d  = ticks_q;
        piezo_d  = piezo_q;
        case (state_q)
            StIdle, StWin, StLose: begin
                if (load) begin
                    melody_d = melody_in;
                    loaded_d = 1'b1;
                end else if (start && loaded_q) begin
                    miss_d  = '0;
                    win_d   = 1'b0;
                    over_d  = 1'b0;
                    len_d   = LenW'(START_LEN);
                    rev_d   = reverse_mode;
                    idx_d   = '0;
                    state_d = StPlayOn;
                    ticks_d = TkW'(ON_TICKS);
                    piezo_d = note_at(melody_q, '0);
                end
            end
            StPlayOn: begin
                if (expire) begin
                    state_d = StPlayOff;
                    ticks_d = TkW'(OFF_TICKS);
                    piezo_d = '0;
                end else if (tick) begin
                    ticks_d = ticks_q - TkW'(1);
                end
            end
            StPlayOff: begin
                if (expire) begin
                    if (play_last) begin
                        state_d = StWaitKey;
                        exp_d   = rev_q ? IdxW'(len_q - LenW'(1)) : '0;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = StPlayOn;
                        ticks_d = TkW'(ON_TICKS);
                        piezo_d = note_at(melody_q, idx_q + IdxW'(1));
                    end
                end else if (tick) begin
                    ticks_d = ticks_q - TkW'(1);
                end
            end
            StWaitKey: begin
                if (key_valid) begin
                    hit_d   = (key_code != '0) && (key_code == note_at(melody_q, exp_q));
                    piezo_d = key_code;
                    state_d = StEcho;
                    ticks_d = TkW'(ECHO_TICKS);
                end
            end
            StEcho: begin
                if (expire) begin
                    piezo_d = '0;
                    if (hit_q && !entry_last) begin
                        exp_d   = rev_q ? exp_q - IdxW'(1) : exp_q + IdxW'(1);
                        state_d = StWaitKey;
                    end else if (hit_q && len_q == LenW'(MAX_NOTES)) begin
                        state_d = StWin;
                        win_d   = 1'b1;
                    end else if (!hit_q && miss_inc == MissW'(LIVES)) begin
                        miss_d  = miss_inc;
                        state_d = StLose;
                        over_d  = 1'b1;
                    end else begin
                        // Replay from the first note: longer prefix on a hit, same one on a miss.
                        if (hit_q) begin
                            len_d = len_q + LenW'(1);
                        end else begin
                            miss_d = miss_inc;
                        end
                        idx_d   = '0;
                        state_d = StPlayOn;
                        ticks_d = TkW'(ON_TICKS);
                        piezo_d = note_at(melody_q, '0);
                    end
                end else if (tick) begin
                    ticks_d = ticks_q - TkW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            melody_q <= '0;
            loaded_q <= 1'b0;
            idx_q    <= '0;
            exp_q    <= '0;
            len_q    <= LenW'(START_LEN);
            miss_q   <= '0;
            rev_q    <= 1'b0;
            hit_q    <= 1'b0;
            win_q    <= 1'b0;
            over_q   <= 1'b0;
            ticks_q  <= '0;
            piezo_q  <= '0;
        end else begin
            state_q  <= state_d;
            melody_q <= melody_d;
            loaded_q <= loaded_d;
            idx_q    <= idx_d;
            exp_q    <= exp_d;
            len_q    <= len_d;
            miss_q   <= miss_d;
            rev_q    <= rev_d;
            hit_q    <= hit_d;
            win_q    <= win_d;
            over_q   <= over_d;
            ticks_q  <= ticks_d;
            piezo_q  <= piezo_d;
        end
    end

    assign piezo_out = piezo_q;
    assign led_out   = piezo_q;
    assign busy      = state_q inside {StPlayOn, StPlayOff, StEcho};
    assign cur_len   = len_q;
    assign miss_cnt  = miss_q;
    assign game_win  = win_q;
    assign game_over = over_q;

endmodule
